// File: rtl/fpu_addsub.sv
// Sequential binary32 add/subtract: six-state walk (IDLE, UNPACK, ALIGN, ADD, NORM, ROUND)
// with flush-to-zero inputs, round-to-nearest-even and IEEE exception flags.
module fpu_addsub (
  input  logic        clk,
  input  logic        arst_n,
  input  logic        start,
  input  logic        sub,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  output logic [31:0] result,
  output logic [3:0]  flags,
  output logic        busy,
  output logic        done
);

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_UNPACK = 3'd1,
    S_ALIGN  = 3'd2,
    S_ADD    = 3'd3,
    S_NORM   = 3'd4,
    S_ROUND  = 3'd5
  } state_t;

  state_t state_r, state_s;

  logic [31:0] opa_r, opb_r;
  logic        sign_l_r, eff_sub_r, special_r, neg_zero_r, zero_r;
  logic [7:0]  exp_l_r, exp_s_r;
  logic [23:0] man_l_r, man_s_r;
  logic [31:0] spec_res_r;
  logic [3:0]  spec_flg_r;
  logic [26:0] small_r, norm_r;
  logic [27:0] sum_r;
  logic signed [9:0] exp_n_r;

  // Leading-zero count of a 27-bit vector; 27 when the vector is zero.
  function automatic logic [4:0] lzc27(input logic [26:0] v);
    lzc27 = 5'd27;
    for (int i = 0; i < 27; i++) begin
      if (v[i]) lzc27 = 5'(26 - i);
    end
  endfunction

  // Field extraction and classification of the captured operands.
  logic [7:0]  exp_a_s, exp_b_s;
  logic [23:0] man_a_s, man_b_s;
  logic        nan_a_s, nan_b_s, inf_a_s, inf_b_s, snan_s, a_big_s;
  assign exp_a_s = opa_r[30:23];
  assign exp_b_s = opb_r[30:23];
  assign man_a_s = (exp_a_s == 8'd0) ? 24'd0 : {1'b1, opa_r[22:0]};
  assign man_b_s = (exp_b_s == 8'd0) ? 24'd0 : {1'b1, opb_r[22:0]};
  assign nan_a_s = (exp_a_s == 8'hFF) && (opa_r[22:0] != 23'd0);
  assign nan_b_s = (exp_b_s == 8'hFF) && (opb_r[22:0] != 23'd0);
  assign inf_a_s = (exp_a_s == 8'hFF) && (opa_r[22:0] == 23'd0);
  assign inf_b_s = (exp_b_s == 8'hFF) && (opb_r[22:0] == 23'd0);
  assign snan_s  = (nan_a_s && !opa_r[22]) || (nan_b_s && !opb_r[22]);
  assign a_big_s = {exp_a_s, man_a_s} >= {exp_b_s, man_b_s};

  logic        spec_s;
  logic [31:0] spec_res_s;
  logic [3:0]  spec_flg_s;

  // Special-operand override decision (NaN / Inf combinations).
  always_comb begin
    spec_s     = 1'b0;
    spec_res_s = 32'd0;
    spec_flg_s = 4'd0;
    if (nan_a_s || nan_b_s) begin
      spec_s     = 1'b1;
      spec_res_s = QNAN;
      spec_flg_s = {snan_s, 3'b000};
    end else if (inf_a_s && inf_b_s) begin
      spec_s = 1'b1;
      if (opa_r[31] != opb_r[31]) begin
        spec_res_s = QNAN;
        spec_flg_s = 4'b1000;
      end else begin
        spec_res_s = opa_r;
      end
    end else if (inf_a_s) begin
      spec_s     = 1'b1;
      spec_res_s = opa_r;
    end else if (inf_b_s) begin
      spec_s     = 1'b1;
      spec_res_s = opb_r;
    end else begin
      spec_s = 1'b0;
    end
  end

  // Alignment: clamp at 26 so a huge difference leaves only the sticky bit.
  logic [7:0]  diff_s;
  logic [4:0]  shamt_s;
  logic [51:0] wide_s;
  logic [26:0] aligned_s;
  assign diff_s    = exp_l_r - exp_s_r;
  assign shamt_s   = (diff_s >= 8'd26) ? 5'd26 : diff_s[4:0];
  assign wide_s    = {man_s_r, 28'd0} >> shamt_s;
  assign aligned_s = {wide_s[51:26], |wide_s[25:0]};

  logic [27:0] sum_s;
  assign sum_s = eff_sub_r ? ({1'b0, man_l_r, 3'b000} - {1'b0, small_r})
                           : ({1'b0, man_l_r, 3'b000} + {1'b0, small_r});

  logic [4:0]        lz_s;
  logic [26:0]       norm_s;
  logic signed [9:0] exp_norm_s;
  assign lz_s = lzc27(sum_r[26:0]);

  // Normalization: right by one on carry-out, else left by the leading-zero count.
  always_comb begin
    norm_s     = 27'd0;
    exp_norm_s = 10'sd0;
    if (sum_r[27]) begin
      norm_s     = {sum_r[27:2], sum_r[1] | sum_r[0]};
      exp_norm_s = $signed({2'b00, exp_l_r}) + 10'sd1;
    end else begin
      norm_s     = sum_r[26:0] << lz_s;
      exp_norm_s = $signed({2'b00, exp_l_r}) - $signed({5'd0, lz_s});
    end
  end

  // Round-to-nearest-even on the guard/round/sticky tail.
  logic              grs_s, round_up_s;
  logic [24:0]       mant_rnd_s;
  logic signed [9:0] exp_fin_s;
  logic [22:0]       frac_s;
  assign grs_s      = norm_r[2] | norm_r[1] | norm_r[0];
  assign round_up_s = norm_r[2] & (norm_r[1] | norm_r[0] | norm_r[3]);
  assign mant_rnd_s = {1'b0, norm_r[26:3]} + {24'd0, round_up_s};
  assign exp_fin_s  = exp_n_r + (mant_rnd_s[24] ? 10'sd1 : 10'sd0);
  assign frac_s     = mant_rnd_s[24] ? mant_rnd_s[23:1] : mant_rnd_s[22:0];

  logic [31:0] res_s;
  logic [3:0]  flg_s;

  // Final packing with overflow/underflow saturation.
  always_comb begin
    res_s = 32'd0;
    flg_s = 4'd0;
    if (special_r) begin
      res_s = spec_res_r;
      flg_s = spec_flg_r;
    end else if (zero_r) begin
      res_s = {neg_zero_r, 31'd0};
    end else if (exp_fin_s >= 10'sd255) begin
      res_s = {sign_l_r, 8'hFF, 23'd0};
      flg_s = 4'b0101;
    end else if (exp_fin_s <= 10'sd0) begin
      res_s = {sign_l_r, 31'd0};
      flg_s = 4'b0011;
    end else begin
      res_s = {sign_l_r, exp_fin_s[7:0], frac_s};
      flg_s = {3'b000, grs_s};
    end
  end

  // Next-state logic: one state per cycle once launched.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start) state_s = S_UNPACK;
        else       state_s = S_IDLE;
      end
      S_UNPACK: state_s = S_ALIGN;
      S_ALIGN:  state_s = S_ADD;
      S_ADD:    state_s = S_NORM;
      S_NORM:   state_s = S_ROUND;
      S_ROUND:  state_s = S_IDLE;
      default:  state_s = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) state_r <= S_IDLE;
    else         state_r <= state_s;
  end

  // Datapath pipeline registers, advanced by the current state.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      opa_r      <= 32'd0;
      opb_r      <= 32'd0;
      sign_l_r   <= 1'b0;
      eff_sub_r  <= 1'b0;
      special_r  <= 1'b0;
      neg_zero_r <= 1'b0;
      zero_r     <= 1'b0;
      exp_l_r    <= 8'd0;
      exp_s_r    <= 8'd0;
      man_l_r    <= 24'd0;
      man_s_r    <= 24'd0;
      spec_res_r <= 32'd0;
      spec_flg_r <= 4'd0;
      small_r    <= 27'd0;
      sum_r      <= 28'd0;
      norm_r     <= 27'd0;
      exp_n_r    <= 10'sd0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (start) begin
            opa_r <= operand_a;
            opb_r <= {operand_b[31] ^ sub, operand_b[30:0]};
          end
        end
        S_UNPACK: begin
          sign_l_r   <= a_big_s ? opa_r[31] : opb_r[31];
          exp_l_r    <= a_big_s ? exp_a_s : exp_b_s;
          man_l_r    <= a_big_s ? man_a_s : man_b_s;
          exp_s_r    <= a_big_s ? exp_b_s : exp_a_s;
          man_s_r    <= a_big_s ? man_b_s : man_a_s;
          eff_sub_r  <= opa_r[31] ^ opb_r[31];
          neg_zero_r <= opa_r[31] & opb_r[31];
          special_r  <= spec_s;
          spec_res_r <= spec_res_s;
          spec_flg_r <= spec_flg_s;
        end
        S_ALIGN: small_r <= aligned_s;
        S_ADD:   sum_r   <= sum_s;
        S_NORM: begin
          norm_r  <= norm_s;
          exp_n_r <= exp_norm_s;
          zero_r  <= (sum_r == 28'd0);
        end
        default: ;
      endcase
    end
  end

  // Handshake and result registers; result/flags move only on the done edge.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      result <= 32'd0;
      flags  <= 4'd0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= (state_r == S_ROUND);
      if (state_r == S_ROUND) begin
        result <= res_s;
        flags  <= flg_s;
      end
      if (state_r == S_IDLE && start) busy <= 1'b1;
      else if (done)                  busy <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fpu_addsub.sv
// Directed-vector bench for fpu_addsub: latency, arithmetic, rounding, exceptions, protocol.
module tb_fpu_addsub;

  logic        clk;
  logic        arst_n;
  logic        start;
  logic        sub;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic [31:0] result;
  logic [3:0]  flags;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  fpu_addsub dut (
    .clk(clk), .arst_n(arst_n), .start(start), .sub(sub),
    .operand_a(operand_a), .operand_b(operand_b),
    .result(result), .flags(flags), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Launch one operation and wait (bounded) for done; lat=0 on timeout.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                        output logic [31:0] res, output logic [3:0] flg, output int lat);
    @(negedge clk);
    operand_a = a; operand_b = b; sub = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; operand_a = 32'hDEAD_BEEF; operand_b = 32'h1234_5678; sub = ~s;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = k;
        break;
      end
    end
    res = result; flg = flags;
  endtask

  task automatic test_reset();
    arst_n = 1'b0; start = 1'b0; sub = 1'b0; operand_a = 32'd0; operand_b = 32'd0;
    #12;
    checks++;
    if ({result, flags, busy, done} !== 38'd0) begin
      errors++;
      $display("FAIL reset: got result=%h flags=%b busy=%b done=%b, want all zero", result, flags, busy, done);
    end
    @(negedge clk); arst_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_latency();
    @(negedge clk);
    operand_a = 32'h3F80_0000; operand_b = 32'h3F80_0000; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL latency_busy: got busy=%b, want 1", busy); end
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0 || busy !== 1'b1) begin
        errors++; $display("FAIL latency_early: cycle %0d done=%b busy=%b, want 0/1", k, done, busy);
      end
    end
    @(posedge clk); #1;
    checks++;
    if ({done, result, flags} !== {1'b1, 32'h4000_0000, 4'b0000}) begin
      errors++; $display("FAIL latency_done: got done=%b result=%h flags=%b, want 1 40000000 0000", done, result, flags);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL latency_drop: got done=%b busy=%b, want 0 0", done, busy);
    end
  endtask

  task automatic test_vectors();
    logic [31:0] va [15] = '{32'h4040_0000, 32'h3F80_0000, 32'h8000_0000, 32'h3F80_0000, 32'h3F80_0000,
                             32'h7F7F_FFFF, 32'h7F80_0000, 32'h7FC0_0000, 32'h3F80_0001, 32'h4000_0000,
                             32'h0080_0001, 32'h0000_0001, 32'h7F80_0001, 32'hFF80_0000, 32'h7F80_0000};
    logic [31:0] vb [15] = '{32'h3F80_0000, 32'h3F80_0000, 32'h8000_0000, 32'h3380_0000, 32'h3380_0001,
                             32'h7F7F_FFFF, 32'hFF80_0000, 32'h3F80_0000, 32'h3F80_0000, 32'hBF80_0000,
                             32'h0080_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h7F80_0000};
    logic        vs [15] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
                             1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [31:0] er [15] = '{32'h4000_0000, 32'h0000_0000, 32'h8000_0000, 32'h3F80_0000, 32'h3F80_0001,
                             32'h7F80_0000, 32'h7FC0_0000, 32'h7FC0_0000, 32'h3400_0000, 32'h3F80_0000,
                             32'h0000_0000, 32'h3F80_0000, 32'h7FC0_0000, 32'hFF80_0000, 32'h7FC0_0000};
    logic [3:0]  ef [15] = '{4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0001,
                             4'b0101, 4'b1000, 4'b0000, 4'b0000, 4'b0000,
                             4'b0011, 4'b0000, 4'b1000, 4'b0000, 4'b1000};
    logic [31:0] res;
    logic [3:0]  flg;
    int          lat;
    for (int i = 0; i < 15; i++) begin
      run_op(va[i], vb[i], vs[i], res, flg, lat);
      checks++;
      if (lat != 5) begin
        errors++; $display("FAIL vec%0d_latency: got %0d cycles, want 5", i, lat);
      end
      checks++;
      if (res !== er[i] || flg !== ef[i]) begin
        errors++;
        $display("FAIL vec%0d_result: %h %s %h got %h/%b, want %h/%b",
                 i, va[i], vs[i] ? "-" : "+", vb[i], res, flg, er[i], ef[i]);
      end
    end
  endtask

  task automatic test_ignore_start();
    @(negedge clk);
    operand_a = 32'h3F80_0000; operand_b = 32'h3F80_0000; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    operand_a = 32'h4040_0000; operand_b = 32'h4040_0000; sub = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
    end
    start = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b1 || result !== 32'h4000_0000) begin
      errors++; $display("FAIL ignore_start: got done=%b result=%h, want 1 40000000", done, result);
    end
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL ignore_start_extra: cycle %0d done=%b busy=%b, want 0 0", k, done, busy);
      end
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    operand_a = 32'h4040_0000; operand_b = 32'h3F80_0000; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    arst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0 || flags !== 4'd0) begin
      errors++; $display("FAIL async_reset: got busy=%b done=%b result=%h flags=%b, want 0 0 0 0", busy, done, result, flags);
    end
    @(negedge clk); arst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0) begin
        errors++; $display("FAIL async_reset_lost: cycle %0d done=%b, want 0", k, done);
      end
    end
  endtask

  task automatic test_after_reset();
    logic [31:0] res;
    logic [3:0]  flg;
    int          lat;
    run_op(32'h4040_0000, 32'h3F80_0000, 1'b1, res, flg, lat);
    checks++;
    if (lat != 5 || res !== 32'h4000_0000 || flg !== 4'b0000) begin
      errors++; $display("FAIL after_reset: got lat=%0d result=%h flags=%b, want 5 40000000 0000", lat, res, flg);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    @(negedge clk);
    operand_a = 32'h3F80_0000; operand_b = 32'h4000_0000; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b1 || result !== 32'h4040_0000) begin
      errors++; $display("FAIL b2b_first: got done=%b result=%h, want 1 40400000", done, result);
    end
    operand_a = 32'h4040_0000; operand_b = 32'h4040_0000; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL b2b_relaunch: got busy=%b done=%b, want 1 0", busy, done);
    end
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = k;
        break;
      end
    end
    checks++;
    if (lat != 5 || result !== 32'h40C0_0000 || flags !== 4'b0000) begin
      errors++; $display("FAIL b2b_second: got lat=%0d result=%h flags=%b, want 5 40C00000 0000", lat, result, flags);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_vectors();
    test_ignore_start();
    test_async_reset();
    test_after_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
